player_motion_ctrl: RTL and testbench

// - Multi-player motion and sprite-select controller for the game display.
// - Per player: integrates joystick keys into an on-screen (X,Y) position once per video frame.
// - Clamps positions to a configurable play area and selects the sprite index
//   (facing / walking frames) handed to the sprite renderer.
// - Generalises the two-player controller: N players, step size, bounds, animation rate,

---
 rtl/player_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Per-player joystick integrator: once per video frame it moves each player,
// clamps to the play area and selects the facing/walking sprite for the renderer.
module player_motion_ctrl #(
  parameter int NPLAYERS = 2,
  parameter int COORD_W  = 10,
  parameter int STEP     = 1,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 768,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 568,
  parameter int INIT_X   = 400,
  parameter int INIT_DX  = 50,
  parameter int INIT_Y   = 300,
  parameter int ANIM_DIV = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          eof,
  input  logic                          enable,
  input  logic [NPLAYERS-1:0]           key_up,
  input  logic [NPLAYERS-1:0]           key_down,
  input  logic [NPLAYERS-1:0]           key_left,
  input  logic [NPLAYERS-1:0]           key_right,
  output logic [NPLAYERS*COORD_W-1:0]   pos_x,
  output logic [NPLAYERS*COORD_W-1:0]   pos_y,
  output logic [NPLAYERS*3-1:0]         sprite_num,
  output logic [NPLAYERS-1:0]           moving
);

  typedef enum logic {IDLE, WALK} state_e;

  typedef enum logic [2:0] {
    FACE   = 3'd0,
    UP1    = 3'd1,
    UP2    = 3'd2,
    RIGHT1 = 3'd3,
    RIGHT2 = 3'd4,
    LEFT1  = 3'd5,
    LEFT2  = 3'd6
  } sprite_e;

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  // Arithmetic is done one bit wider than a coordinate so nothing wraps.
  localparam logic [COORD_W:0] STEP_W  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] X_MIN_W = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0] X_MAX_W = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] Y_MIN_W = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0] Y_MAX_W = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W:0] X_LO_W  = X_MIN_W + STEP_W;
  localparam logic [COORD_W:0] Y_LO_W  = Y_MIN_W + STEP_W;

  logic eof_d;
  logic eof_armed;
  logic tick;

  // eof_armed blocks a tick until eof has been seen low after reset, so an eof
  // level still high when reset releases is not mistaken for a new frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eof_d     <= 1'b0;
      eof_armed <= 1'b0;
    end else begin
      eof_d <= eof;
      if (!eof) eof_armed <= 1'b1;
    end
  end

  assign tick = eof & ~eof_d & eof_armed & enable;

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_player
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    sprite_e            facing_q, facing_d;
    sprite_e            sprite_q, sprite_d;
    logic               vert, horz;
    logic [COORD_W:0]   x_inc, x_dec, y_inc, y_dec;

    assign vert  = key_up[i] ^ key_down[i];
    assign horz  = key_left[i] ^ key_right[i];
    assign x_inc = {1'b0, x_q} + STEP_W;
    assign x_dec = {1'b0, x_q} - STEP_W;
    assign y_inc = {1'b0, y_q} + STEP_W;
    assign y_dec = {1'b0, y_q} - STEP_W;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_q      <= COORD_W'(INIT_X + i * INIT_DX);
        y_q      <= COORD_W'(INIT_Y);
        state_q  <= IDLE;
        phase_q  <= 1'b0;
        cnt_q    <= '0;
        facing_q <= FACE;
        sprite_q <= FACE;
      end else begin
        x_q      <= x_d;
        y_q      <= y_d;
        state_q  <= state_d;
        phase_q  <= phase_d;
        cnt_q    <= cnt_d;
        facing_q <= facing_d;
        sprite_q <= sprite_d;
      end
    end

    // NOTE: every output of this block is assigned a hold value first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      facing_d = facing_q;
      sprite_d = sprite_q;

      if (tick) begin
        if (vert) begin
          if (key_up[i]) y_d = ({1'b0, y_q} < Y_LO_W) ? COORD_W'(Y_MIN) : y_dec[COORD_W-1:0];
          else           y_d = (y_inc > Y_MAX_W)      ? COORD_W'(Y_MAX) : y_inc[COORD_W-1:0];
        end
        if (horz) begin
          if (key_left[i]) x_d = ({1'b0, x_q} < X_LO_W) ? COORD_W'(X_MIN) : x_dec[COORD_W-1:0];
          else             x_d = (x_inc > X_MAX_W)      ? COORD_W'(X_MAX) : x_inc[COORD_W-1:0];
        end

        if (vert || horz) begin
          state_d = WALK;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Sprite uses the post-update phase; vertical wins over horizontal.
          if (vert && key_up[i]) begin
            sprite_d = phase_d ? UP2 : UP1;
            facing_d = UP1;
          end else if (vert) begin
            sprite_d = phase_d ? UP2 : FACE;
            facing_d = FACE;
          end else if (key_left[i]) begin
            sprite_d = phase_d ? LEFT2 : LEFT1;
            facing_d = LEFT1;
          end else begin
            sprite_d = phase_d ? RIGHT2 : RIGHT1;
            facing_d = RIGHT1;
          end
        end else begin
          state_d  = IDLE;
          cnt_d    = '0;
          phase_d  = 1'b0;
          sprite_d = facing_q;
        end
      end
    end

    assign pos_x[i*COORD_W +: COORD_W] = x_q;
    assign pos_y[i*COORD_W +: COORD_W] = y_q;
    assign sprite_num[3*i +: 3]        = sprite_q;
    assign moving[i]                   = (state_q == WALK);
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: reset values, walking, clamping,
// opposite-key cancel, eof edge handling, freeze and reset mid-walk.
module tb_player_motion_ctrl;

  localparam int NP = 2;
  localparam int CW = 10;

  logic             clk;
  logic             reset;
  logic             eof;
  logic             enable;
  logic [NP-1:0]    key_up, key_down, key_left, key_right;
  logic [NP*CW-1:0] pos_x, pos_y;
  logic [NP*3-1:0]  sprite_num;
  logic [NP-1:0]    moving;

  int n_checks = 0;
  int n_pass   = 0;

  player_motion_ctrl #(
    .NPLAYERS(NP), .COORD_W(CW), .STEP(1),
    .X_MIN(0), .X_MAX(768), .Y_MIN(0), .Y_MAX(568),
    .INIT_X(400), .INIT_DX(50), .INIT_Y(300), .ANIM_DIV(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .eof        (eof),
    .enable     (enable),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .sprite_num (sprite_num),
    .moving     (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int px(input int p); return int'(pos_x[p*CW +: CW]); endfunction
  function automatic int py(input int p); return int'(pos_y[p*CW +: CW]); endfunction
  function automatic int sp(input int p); return int'(sprite_num[3*p +: 3]); endfunction

  // One clean eof pulse spanning a single rising clock edge; returns at the
  // following falling edge, where the updated outputs are stable.
  task automatic tick();
    @(negedge clk) eof = 1'b1;
    @(negedge clk) eof = 1'b0;
  endtask

  task automatic clear_keys();
    key_up = '0; key_down = '0; key_left = '0; key_right = '0;
  endtask

  task automatic check_home(input string tag);
    n_checks++;
    if (px(0) !== 400 || py(0) !== 300 || px(1) !== 450 || py(1) !== 300)
      $display("FAIL %s_pos got (%0d,%0d),(%0d,%0d) want (400,300),(450,300)",
               tag, px(0), py(0), px(1), py(1));
    else n_pass++;
    n_checks++;
    if (sprite_num !== 6'd0 || moving !== 2'b00)
      $display("FAIL %s_sprite_moving got sprite=%h moving=%b want sprite=0 moving=00",
               tag, sprite_num, moving);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; eof = 1'b0; enable = 1'b1; clear_keys();
    repeat (3) @(negedge clk);
    check_home("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    check_home("idle_tick");
  endtask

  task automatic test_walk_right();
    int exp_sp;
    key_right[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_sp = (t < 8) ? 3 : 4;
      n_checks++;
      if (sp(0) !== exp_sp || moving[0] !== 1'b1)
        $display("FAIL right_t%0d got sprite=%0d moving=%b want sprite=%0d moving=1",
                 t, sp(0), moving[0], exp_sp);
      else n_pass++;
    end
    n_checks++;
    if (px(0) !== 410 || py(0) !== 300 || px(1) !== 450)
      $display("FAIL right_pos got x0=%0d y0=%0d x1=%0d want 410 300 450", px(0), py(0), px(1));
    else n_pass++;
    key_right[0] = 1'b0;
    tick();
    n_checks++;
    if (moving[0] !== 1'b0 || sp(0) !== 3 || px(0) !== 410)
      $display("FAIL right_release got moving=%b sprite=%0d x=%0d want 0 3 410",
               moving[0], sp(0), px(0));
    else n_pass++;
  endtask

  task automatic test_clamp();
    key_up[1] = 1'b1;
    repeat (299) tick();
    n_checks++;
    if (py(1) !== 1) $display("FAIL up_reach1 got y1=%0d want 1", py(1));
    else n_pass++;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if (py(1) !== 0 || moving[1] !== 1'b1)
        $display("FAIL up_clamp_t%0d got y1=%0d moving=%b want y1=0 moving=1", t, py(1), moving[1]);
      else n_pass++;
    end
    // 302 walking ticks: 37 phase toggles, so phase=1 -> UP2.
    n_checks++;
    if (sp(1) !== 2) $display("FAIL up_sprite got %0d want 2", sp(1));
    else n_pass++;
    key_up[1] = 1'b0;
    tick();
    n_checks++;
    if (sp(1) !== 1 || moving[1] !== 1'b0)
      $display("FAIL up_release got sprite=%0d moving=%b want 1 0", sp(1), moving[1]);
    else n_pass++;

    key_right[1] = 1'b1;
    repeat (318) tick();
    n_checks++;
    if (px(1) !== 768) $display("FAIL right_reach_max got x1=%0d want 768", px(1));
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (px(1) !== 768 || moving[1] !== 1'b1)
      $display("FAIL right_clamp got x1=%0d moving=%b want 768 1", px(1), moving[1]);
    else n_pass++;
    key_right[1] = 1'b0;
    tick();
  endtask

  task automatic test_cancel();
    int exp_sp;
    key_left[0] = 1'b1; key_right[0] = 1'b1; key_down[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_sp = (t < 8) ? 0 : 2;
      n_checks++;
      if (px(0) !== 410 || py(0) !== 300 + t || sp(0) !== exp_sp || moving[0] !== 1'b1)
        $display("FAIL cancel_t%0d got x=%0d y=%0d sprite=%0d moving=%b want 410 %0d %0d 1",
                 t, px(0), py(0), sp(0), moving[0], 300 + t, exp_sp);
      else n_pass++;
    end
    clear_keys();
    tick();
    n_checks++;
    if (sp(0) !== 0 || moving[0] !== 1'b0)
      $display("FAIL cancel_release got sprite=%0d moving=%b want 0 0", sp(0), moving[0]);
    else n_pass++;
    key_up[0] = 1'b1; key_down[0] = 1'b1; key_left[0] = 1'b1;
    tick();
    n_checks++;
    if (px(0) !== 409 || py(0) !== 310 || sp(0) !== 5)
      $display("FAIL cancel_vert got x=%0d y=%0d sprite=%0d want 409 310 5", px(0), py(0), sp(0));
    else n_pass++;
    clear_keys();
    tick();
  endtask

  task automatic test_long_eof_freeze();
    key_right[0] = 1'b1;
    @(negedge clk) eof = 1'b1;
    repeat (50) @(negedge clk);
    eof = 1'b0;
    @(negedge clk);
    n_checks++;
    if (px(0) !== 410 || sp(0) !== 3 || moving[0] !== 1'b1)
      $display("FAIL long_eof got x=%0d sprite=%0d moving=%b want 410 3 1", px(0), sp(0), moving[0]);
    else n_pass++;

    enable = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (px(0) !== 410 || sp(0) !== 3 || moving[0] !== 1'b1)
      $display("FAIL freeze got x=%0d sprite=%0d moving=%b want 410 3 1", px(0), sp(0), moving[0]);
    else n_pass++;

    @(negedge clk) eof = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    eof = 1'b0;
    @(negedge clk);
    n_checks++;
    if (px(0) !== 410) $display("FAIL resume_no_replay got x=%0d want 410", px(0));
    else n_pass++;

    tick();
    n_checks++;
    if (px(0) !== 411) $display("FAIL resume_tick got x=%0d want 411", px(0));
    else n_pass++;
    key_right[0] = 1'b0;
    tick();
    n_checks++;
    if (moving[0] !== 1'b0 || sp(0) !== 3)
      $display("FAIL resume_release got moving=%b sprite=%0d want 0 3", moving[0], sp(0));
    else n_pass++;
  endtask

  task automatic test_reset_mid_walk();
    key_right[0] = 1'b1;
    tick();
    n_checks++;
    if (px(0) !== 412 || moving[0] !== 1'b1)
      $display("FAIL prewalk got x=%0d moving=%b want 412 1", px(0), moving[0]);
    else n_pass++;
    @(negedge clk) eof = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_home("reset_async");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    check_home("reset_eof_high");
    eof = 1'b0;
    @(negedge clk);
    tick();
    n_checks++;
    if (px(0) !== 401 || sp(0) !== 3 || moving[0] !== 1'b1)
      $display("FAIL post_reset_tick got x=%0d sprite=%0d moving=%b want 401 3 1",
               px(0), sp(0), moving[0]);
    else n_pass++;
    clear_keys();
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_clamp();
    test_cancel();
    test_long_eof_freeze();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
